// File: rtl/nyq_pkg.sv
// Shared definitions for the NYQ block: counter FSM states, direction
// encodings and the default index width.
package nyq_pkg;

  typedef enum logic {
    NYQ_CNT_RUN  = 1'b0,
    NYQ_CNT_DONE = 1'b1
  } nyq_cnt_state_e;

  localparam bit NYQ_DIR_UP   = 1'b0;
  localparam bit NYQ_DIR_DOWN = 1'b1;

  localparam int NYQ_WIDTH = 3;

endpackage : nyq_pkg

// File: rtl/nyq_mod_counter.sv
// Up/down modulo counter with programmable limit, clear/load, one-shot stop
// and a tally of completed wraps; drives the NYQ sample/phase index.
module nyq_mod_counter
  import nyq_pkg::*;
#(
  parameter int WIDTH  = NYQ_WIDTH,
  parameter int WRAP_W = 8,
  parameter bit DOWN   = NYQ_DIR_DOWN
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              En_SI,
  input  logic              Clr_SI,
  input  logic              Load_SI,
  input  logic [WIDTH-1:0]  LoadVal_DI,
  input  logic [WIDTH-1:0]  Max_DI,
  input  logic              OneShot_SI,
  output logic [WIDTH-1:0]  Cnt_Out_DO,
  output logic              Tc_SO,
  output logic              Wrap_SO,
  output logic [WRAP_W-1:0] WrapCnt_DO,
  output logic              Done_SO
);

  localparam logic [WIDTH-1:0] CNT_RST = (DOWN == NYQ_DIR_DOWN) ? '1 : '0;

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  start_val;
  nyq_cnt_state_e    state_q, state_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              at_term;
  logic              advance;
  logic              wrap_evt;
  logic              stop_evt;

  // Up mode treats anything at or above the limit as terminal so an
  // out-of-range load or a lowered limit still wraps on the next step.
  always_comb begin
    start_val = (DOWN == NYQ_DIR_DOWN) ? Max_DI : '0;
    at_term   = (DOWN == NYQ_DIR_DOWN) ? (cnt_q == '0) : (cnt_q >= Max_DI);
    advance   = !Clr_SI && !Load_SI && En_SI && (state_q == NYQ_CNT_RUN);
    wrap_evt  = advance && at_term && !OneShot_SI;
    stop_evt  = advance && at_term && OneShot_SI;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Clr_SI) begin
      cnt_d = start_val;
    end else if (Load_SI) begin
      cnt_d = LoadVal_DI;
    end else if (advance && !at_term) begin
      cnt_d = (DOWN == NYQ_DIR_DOWN) ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
    end else if (wrap_evt) begin
      cnt_d = start_val;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Clr_SI || Load_SI) begin
      state_d = NYQ_CNT_RUN;
    end else if (stop_evt) begin
      state_d = NYQ_CNT_DONE;
    end
  end

  always_comb begin
    wrap_d     = wrap_evt;
    wrap_cnt_d = wrap_cnt_q;
    if (Clr_SI) begin
      wrap_cnt_d = '0;
    end else if (wrap_evt) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q <= NYQ_CNT_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign Cnt_Out_DO = cnt_q;
  assign Tc_SO      = (state_q == NYQ_CNT_RUN) && at_term;
  assign Wrap_SO    = wrap_q;
  assign WrapCnt_DO = wrap_cnt_q;
  assign Done_SO    = (state_q == NYQ_CNT_DONE);

endmodule : nyq_mod_counter
